result_ascii_tx: RTL

RESULT_ASCII_TX -- requirements
Module: result_ascii_tx

---
 rtl/aoc_pkg.sv | 30 +++
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/result_ascii_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/aoc_pkg.sv
// Shared definitions for the result ASCII transmitter: ASCII constants,
// FSM state encoding, emit sequencing phases and a digit-to-ASCII helper.
package aoc_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_EMIT,
        ST_FIN
    } tx_state_t;

    typedef enum logic [2:0] {
        PH_LABEL,
        PH_COLON,
        PH_DIGIT,
        PH_CR,
        PH_LF
    } emit_phase_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO | {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// DATA_WIDTH steps after load; done rises together with the final BCD value.
module bin2bcd_seq
    import aoc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] value,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [DIGITS*4-1:0]   bcd_q;
    logic [DIGITS*4-1:0]   adj_d;
    logic [CW-1:0]         cnt_q;
    logic                  done_q;

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] > 4'd4) begin
                adj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (load) begin
            shift_q <= value;
            bcd_q   <= '0;
            cnt_q   <= CW'(DATA_WIDTH);
            done_q  <= 1'b0;
        end else if (cnt_q != '0) begin
            // Adjusted digits and the binary operand shift left as one register.
            {bcd_q, shift_q} <= {adj_d[DIGITS*4-2:0], shift_q, 1'b0};
            cnt_q            <= cnt_q - CW'(1);
            done_q           <= (cnt_q == CW'(1));
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/result_ascii_tx.sv
// Streams "1:<part1><eol>2:<part2><eol>" as ASCII over a valid/ready port.
// Define RESULT_TX_CRLF_EN for CR LF line endings (default: LF only).
module result_ascii_tx
    import aoc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] part1_result,
    input  logic [DATA_WIDTH-1:0] part2_result,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  finished
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    tx_state_t             state_q;
    emit_phase_t           phase_q;
    logic                  part_q;
    logic [DATA_WIDTH-1:0] p1_q;
    logic [DATA_WIDTH-1:0] p2_q;
    logic [7:0]            out_data_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  finished_q;
    logic [IW-1:0]         dig_q;
    logic [CW-1:0]         conv_cnt_q;

    logic                  conv_load_d;
    logic [DATA_WIDTH-1:0] conv_value_d;
    logic [DIGITS*4-1:0]   conv_bcd;
    logic                  conv_done;
    logic [IW-1:0]         lead_d;
    logic [IW-1:0]         dig_dec_d;
    logic [3:0]            digits [DIGITS];

    assign conv_load_d  = (state_q == ST_LOAD);
    assign conv_value_d = part_q ? p2_q : p1_q;
    assign dig_dec_d    = dig_q - IW'(1);

    bin2bcd_seq #(
        .DATA_WIDTH(DATA_WIDTH),
        .DIGITS    (DIGITS)
    ) u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .load (conv_load_d),
        .value(conv_value_d),
        .bcd  (conv_bcd),
        .done (conv_done)
    );

    // Highest non-zero digit position; zero maps to position 0 so "0" is sent.
    always_comb begin
        lead_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digits[i] = conv_bcd[i*4 +: 4];
            if (conv_bcd[i*4 +: 4] != 4'd0) begin
                lead_d = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_LABEL;
            part_q      <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            dig_q       <= '0;
            conv_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !finished_q) begin
                        p1_q    <= part1_result;
                        p2_q    <= part2_result;
                        part_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    conv_cnt_q <= CW'(DATA_WIDTH - 1);
                    state_q    <= ST_CONV;
                end
                ST_CONV: begin
                    if (conv_cnt_q == '0) begin
                        state_q <= ST_EMIT;
                    end else begin
                        conv_cnt_q <= conv_cnt_q - CW'(1);
                    end
                end
                ST_EMIT: begin
                    // First EMIT cycle only primes the label byte.
                    if (!out_valid_q) begin
                        if (conv_done) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= ascii_digit(part_q ? 4'd2 : 4'd1);
                            phase_q     <= PH_LABEL;
                        end
                    end else if (out_ready) begin
                        case (phase_q)
                            PH_LABEL: begin
                                out_data_q <= ASCII_COLON;
                                phase_q    <= PH_COLON;
                            end
                            PH_COLON: begin
                                out_data_q <= ascii_digit(digits[lead_d]);
                                dig_q      <= lead_d;
                                phase_q    <= PH_DIGIT;
                            end
                            PH_DIGIT: begin
                                if (dig_q == '0) begin
`ifdef RESULT_TX_CRLF_EN
                                    out_data_q <= ASCII_CR;
                                    phase_q    <= PH_CR;
`else
                                    out_data_q <= ASCII_LF;
                                    phase_q    <= PH_LF;
`endif
                                end else begin
                                    out_data_q <= ascii_digit(digits[dig_dec_d]);
                                    dig_q      <= dig_dec_d;
                                end
                            end
                            PH_CR: begin
                                out_data_q <= ASCII_LF;
                                phase_q    <= PH_LF;
                            end
                            default: begin
                                out_valid_q <= 1'b0;
                                phase_q     <= PH_LABEL;
                                if (!part_q) begin
                                    part_q  <= 1'b1;
                                    state_q <= ST_LOAD;
                                end else begin
                                    busy_q     <= 1'b0;
                                    finished_q <= 1'b1;
                                    state_q    <= ST_FIN;
                                end
                            end
                        endcase
                    end
                end
                ST_FIN: begin
                    busy_q     <= 1'b0;
                    finished_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign finished  = finished_q;

endmodule
